// File: rtl/sp_ram_arbiter_if.sv
// Bus bundle between the two core masters (instruction fetch, data/loader)
// and the single-port on-chip RAM. The arbiter takes the slave view; the
// surrounding core/RAM environment takes the master view.
interface sp_ram_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m0_req_i;
  logic              m0_gnt_o;
  logic              m0_rvalid_o;
  logic [ADDR_W-1:0] m0_addr_i;
  logic              m0_we_i;
  logic [DATA_W-1:0] m0_wdata_i;
  logic [DATA_W-1:0] m0_rdata_o;

  logic              m1_req_i;
  logic              m1_gnt_o;
  logic              m1_rvalid_o;
  logic [ADDR_W-1:0] m1_addr_i;
  logic              m1_we_i;
  logic [DATA_W-1:0] m1_wdata_i;
  logic [DATA_W-1:0] m1_rdata_o;

  logic              mem_req_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_we_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;

  modport slave (
    input  m0_req_i, m0_addr_i, m0_we_i, m0_wdata_i,
    output m0_gnt_o, m0_rvalid_o, m0_rdata_o,
    input  m1_req_i, m1_addr_i, m1_we_i, m1_wdata_i,
    output m1_gnt_o, m1_rvalid_o, m1_rdata_o,
    output mem_req_o, mem_addr_o, mem_we_o, mem_wdata_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );

  modport master (
    output m0_req_i, m0_addr_i, m0_we_i, m0_wdata_i,
    input  m0_gnt_o, m0_rvalid_o, m0_rdata_o,
    output m1_req_i, m1_addr_i, m1_we_i, m1_wdata_i,
    input  m1_gnt_o, m1_rvalid_o, m1_rdata_o,
    input  mem_req_o, mem_addr_o, mem_we_o, mem_wdata_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i
  );
endinterface

// File: rtl/sp_ram_arbiter.sv
// Two-master round-robin arbiter in front of the single-port RAM.
// Read data is captured in the grant cycle into a small response FIFO and
// handed back to the owning master when the RAM signals rvalid, so responses
// always return in grant order.
module sp_ram_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  sp_ram_arbiter_if.slave   bus,
  output logic              err_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              r_prio;
  logic              r_startMask;
  logic              r_err;
  logic [PTR_W-1:0]  r_wrPtr;
  logic [PTR_W-1:0]  r_rdPtr;
  logic [CNT_W-1:0]  r_count;
  logic              r_fifoOwner [DEPTH];
  logic [DATA_W-1:0] r_fifoData  [DEPTH];

  logic              w_sel;
  logic              w_anyReq;
  logic              w_full;
  logic              w_empty;
  logic              w_memReq;
  logic              w_grant;
  logic              w_pop;
  logic              w_headOwner;
  logic [ADDR_W-1:0] w_addr;

  // Selection, request forwarding and response routing are all combinational
  // so a 1-cycle RAM sees one access per cycle.
  always_comb begin
    w_anyReq    = bus.m0_req_i | bus.m1_req_i;
    w_sel       = (bus.m0_req_i & bus.m1_req_i) ? r_prio : bus.m1_req_i;
    w_full      = (r_count == CNT_W'(DEPTH));
    w_empty     = (r_count == '0);
    w_memReq    = w_anyReq & ~w_full;
    w_grant     = w_memReq & bus.mem_gnt_i;
    w_pop       = bus.mem_rvalid_i & ~w_empty & ~rst;
    w_headOwner = r_fifoOwner[r_rdPtr];
    w_addr      = w_sel ? bus.m1_addr_i : bus.m0_addr_i;

    bus.mem_req_o   = w_memReq;
    bus.mem_addr_o  = w_addr;
    bus.mem_we_o    = w_sel ? bus.m1_we_i    : bus.m0_we_i;
    bus.mem_wdata_o = w_sel ? bus.m1_wdata_i : bus.m0_wdata_i;

    bus.m0_gnt_o    = w_grant & ~w_sel;
    bus.m1_gnt_o    = w_grant &  w_sel;
    bus.m0_rvalid_o = w_pop & ~w_headOwner;
    bus.m1_rvalid_o = w_pop &  w_headOwner;
    bus.m0_rdata_o  = r_fifoData[r_rdPtr];
    bus.m1_rdata_o  = r_fifoData[r_rdPtr];
  end

  // Round-robin pointer hands priority to the loser of each grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prio <= 1'b0;
    end else if (w_grant) begin
      r_prio <= ~w_sel;
    end
  end

  // Response FIFO: push {owner, rdata} on every grant, pop on every matched rvalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_grant) begin
        r_fifoOwner[r_wrPtr] <= w_sel;
        r_fifoData[r_wrPtr]  <= bus.mem_rdata_i;
        r_wrPtr <= (r_wrPtr == PTR_W'(DEPTH - 1)) ? '0 : r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= (r_rdPtr == PTR_W'(DEPTH - 1)) ? '0 : r_rdPtr + PTR_W'(1);
      end
      case ({w_grant, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky error on an rvalid with nothing outstanding; ignored in the first
  // cycle after reset so a response to a pre-reset access is harmless.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err       <= 1'b0;
      r_startMask <= 1'b1;
    end else begin
      r_startMask <= 1'b0;
      if (bus.mem_rvalid_i && w_empty && !r_startMask) begin
        r_err <= 1'b1;
      end
    end
  end

  assign err_o = r_err;

endmodule

// File: doc/sp_ram_arbiter.md
Name: sp_ram_arbiter

Overview:
- Two-master round-robin arbiter that shares the single req/gnt/rvalid port of the on-chip single-port RAM.
- Master 0 is the core instruction fetch; master 1 is the core data / loader path.
- Requests are muxed onto the RAM port. The combinational read data is captured in the grant cycle, and each response is routed back to the master that owned the grant, in grant order.
- Sits between the core LSU/IF ports and the RAM.

Parameters:
- ADDR_W, 32, address width on all ports.
- DATA_W, 32, data width on all ports.
- DEPTH, 2, outstanding-response FIFO entries (power of two, ≥1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- m0_req_i  in  1  master 0 request
- m0_gnt_o  out  1  master 0 grant
- m0_rvalid_o  out  1  master 0 response valid
- m0_addr_i  in  ADDR_W  master 0 address
- m0_we_i  in  1  master 0 write enable
- m0_wdata_i  in  DATA_W  master 0 write data
- m0_rdata_o  out  DATA_W  master 0 read data
- m1_req_i, m1_gnt_o, m1_rvalid_o, m1_addr_i, m1_we_i, m1_wdata_i, m1_rdata_o: same as the m0 ports, for master 1
- mem_req_o  out  1  RAM request
- mem_gnt_i  in  1  RAM grant
- mem_rvalid_i  in  1  RAM response valid
- mem_addr_o  out  ADDR_W  RAM address
- mem_we_o  out  1  RAM write enable
- mem_wdata_o  out  DATA_W  RAM write data
- mem_rdata_i  in  DATA_W  RAM read data (combinational on mem_addr_o)
- err_o  out  1  sticky protocol error

Behaviour:
- Reset (rst=1 at posedge):
  - priority pointer = 0; FIFO empty; err_o = 0; startup mask set.
  - Consequently all rvalid outputs are 0. gnt/req outputs are 0 while no master requests.
- Selection (combinational):
  - If only one master requests, it is selected.
  - If both request, the master equal to the priority pointer is selected.
- Request forwarding:
  - mem_req_o = (m0_req_i | m1_req_i) & !fifo_full.
  - mem_addr_o, mem_we_o and mem_wdata_o are taken from the selected master. When no master requests, they are taken from master 0.
- Grant:
  - mX_gnt_o = mem_req_o & mem_gnt_i & (sel==X).
  - Only one master is ever granted per cycle.
  - A master holds req/addr/we/wdata stable until granted.
- Grant cycle (mem_req_o & mem_gnt_i):
  - Push {owner, mem_rdata_i} into the FIFO; write grants also push an entry.
  - Priority pointer becomes the non-granted master, so strict alternation occurs under continuous contention.
  - Without a grant, the pointer holds.
- Response:
  - mX_rvalid_o = mem_rvalid_i & !fifo_empty & (head.owner==X).
  - m0_rdata_o = m1_rdata_o = head.rdata.
  - FIFO pops on mem_rvalid_i & !fifo_empty.
  - Writes receive an rvalid whose rdata is the pre-write RAM content. Masters ignore it.
  - Latency: with a 1-cycle RAM, rvalid arrives 1 cycle after gnt.
- Back-to-back and full:
  - Push and pop in the same cycle are allowed; occupancy is unchanged.
  - A full FIFO blocks mem_req_o even if a pop occurs that cycle, so there is no full-bypass.
  - With DEPTH=2 and a 1-cycle RAM, throughput is one access per cycle.
- Error:
  - mem_rvalid_i with an empty FIFO sets err_o. err_o stays set until reset.
  - No pop, and no master rvalid, is generated for that event.
  - Exception: during the first cycle after rst deasserts (startup mask), a stray rvalid is ignored and does not set err_o. The mask clears after one cycle.
- Reset mid-operation: outstanding entries are discarded; no rvalid is delivered to either master for them.
- Counters: FIFO pointers are log2(DEPTH) bits and wrap naturally. Occupancy is log2(DEPTH)+1 bits.

Test Plan:
- Reset, then m0 read at addr 0x04 (RAM holds 0x0000_0015):
  - m0_gnt_o=1 in cycle 0; m0_rvalid_o=1 with m0_rdata_o=0x15 in cycle 1.
  - m1 signals stay 0; err_o=0.
- Both masters request reads continuously for 6 cycles:
  - Grants alternate m0,m1,m0,m1,m0,m1.
  - Each rvalid goes to the matching master one cycle later with the data of its own address.
- m1 writes 0xDEAD_BEEF to addr 0x10, then m0 reads 0x10 in the next cycle:
  - m1_rvalid_o pulses once.
  - m0 then receives 0xDEAD_BEEF.
- Hold mem_gnt_i=1 but mem_rvalid_i=0 (stalled RAM model) while m0 requests:
  - Two grants are issued; mem_req_o then drops (FIFO full).
  - Releasing rvalid for 2 cycles returns both responses in order, and requests resume.
- Inject mem_rvalid_i with an empty FIFO 3 cycles after reset:
  - err_o goes 1 and stays 1; no master rvalid.
  - The same injection in the first cycle after reset leaves err_o=0.
- Assert rst while one read is outstanding:
  - The following rvalid is not forwarded to either master.
  - The priority pointer restarts at 0 (m0 wins the next contention).
